// File: rtl/max6682_spi_responder_if.sv
// SPI pins and sensor-side status of the MAX6682 responder, grouped for the
// device (slave) side and the bus master / bench side.
interface max6682_spi_responder_if;
    logic        sck;
    logic        cs_n;
    logic        so;
    logic        so_enable;
    logic [10:0] temperature;
    logic        conv_busy;
    logic [7:0]  frames;
    logic        short_frame;

    modport slave (
        input  sck,
        input  cs_n,
        input  temperature,
        output so,
        output so_enable,
        output conv_busy,
        output frames,
        output short_frame
    );

    modport master (
        output sck,
        output cs_n,
        output temperature,
        input  so,
        input  so_enable,
        input  conv_busy,
        input  frames,
        input  short_frame
    );
endinterface

// File: rtl/max6682_spi_responder.sv
// MAX6682 SPI slave model: timed conversions while CS is high, MSB-first shift-out
// of the last converted temperature under CPOL=0/CPHA=0, single system clock.
module max6682_spi_responder #(
    parameter int ConvCycles = 16,
    parameter int FrameBits  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic srst,
    max6682_spi_responder_if.slave bus
);
    localparam int CNT_W  = $clog2(ConvCycles);
    localparam int RISE_W = $clog2(FrameBits + 1);
    localparam int PAD_W  = FrameBits - 11;
    localparam logic [CNT_W-1:0]  CONV_LOAD = CNT_W'(ConvCycles - 1);
    localparam logic [RISE_W-1:0] RISE_FULL = RISE_W'(FrameBits);

    typedef enum logic [1:0] {
        ST_CONVERT = 2'b00,
        ST_READY   = 2'b01,
        ST_SHIFT   = 2'b10
    } state_t;

    // [0],[1] synchronize the pin; [2] is the previous synchronized value
    logic [2:0] sck_sync_r;
    logic [2:0] cs_sync_r;
    logic       sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      conv_cnt_r, conv_cnt_s;
    logic [10:0]           conv_reg_r, conv_reg_s;
    logic [FrameBits-1:0]  shift_r, shift_s;
    logic                  so_r, so_s;
    logic                  so_en_r, so_en_s;
    logic                  busy_r, busy_s;
    logic [7:0]            frames_r, frames_s;
    logic                  short_r, short_s;
    logic [RISE_W-1:0]     rise_cnt_r, rise_cnt_s;

    // Pin synchronizers; CS idles high so its chain resets to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_r <= 3'b000;
            cs_sync_r  <= 3'b111;
        end else if (srst) begin
            sck_sync_r <= 3'b000;
            cs_sync_r  <= 3'b111;
        end else begin
            sck_sync_r <= {sck_sync_r[1:0], bus.sck};
            cs_sync_r  <= {cs_sync_r[1:0], bus.cs_n};
        end
    end

    assign sck_rise_s =  sck_sync_r[1] & ~sck_sync_r[2];
    assign sck_fall_s = ~sck_sync_r[1] &  sck_sync_r[2];
    assign cs_rise_s  =  cs_sync_r[1]  & ~cs_sync_r[2];
    assign cs_fall_s  = ~cs_sync_r[1]  &  cs_sync_r[2];

    // Next-state and next-output logic of the conversion/shift FSM
    always_comb begin
        state_s    = state_r;
        conv_cnt_s = conv_cnt_r;
        conv_reg_s = conv_reg_r;
        shift_s    = shift_r;
        so_s       = so_r;
        so_en_s    = so_en_r;
        busy_s     = busy_r;
        frames_s   = frames_r;
        short_s    = 1'b0;
        rise_cnt_s = rise_cnt_r;
        case (state_r)
            ST_CONVERT: begin
                // A CS fall aborts the conversion and serves the previous result
                if (cs_fall_s) begin
                    shift_s    = {conv_reg_r, {PAD_W{1'b0}}};
                    so_s       = conv_reg_r[10];
                    so_en_s    = 1'b1;
                    rise_cnt_s = {RISE_W{1'b0}};
                    busy_s     = 1'b0;
                    state_s    = ST_SHIFT;
                end else if (conv_cnt_r == {CNT_W{1'b0}}) begin
                    conv_reg_s = bus.temperature;
                    busy_s     = 1'b0;
                    state_s    = ST_READY;
                end else begin
                    conv_cnt_s = conv_cnt_r - CNT_W'(1'b1);
                end
            end
            ST_READY: begin
                if (cs_fall_s) begin
                    shift_s    = {conv_reg_r, {PAD_W{1'b0}}};
                    so_s       = conv_reg_r[10];
                    so_en_s    = 1'b1;
                    rise_cnt_s = {RISE_W{1'b0}};
                    busy_s     = 1'b0;
                    state_s    = ST_SHIFT;
                end else begin
                    state_s    = ST_READY;
                end
            end
            ST_SHIFT: begin
                // CS rise has priority over any SCK edge seen in the same cycle
                if (cs_rise_s) begin
                    so_s       = 1'b0;
                    so_en_s    = 1'b0;
                    if (rise_cnt_r == RISE_FULL) begin
                        frames_s = frames_r + 8'd1;
                    end else begin
                        short_s  = 1'b1;
                    end
                    conv_cnt_s = CONV_LOAD;
                    busy_s     = 1'b1;
                    state_s    = ST_CONVERT;
                end else if (sck_rise_s) begin
                    if (rise_cnt_r != RISE_FULL) begin
                        rise_cnt_s = rise_cnt_r + RISE_W'(1'b1);
                    end else begin
                        rise_cnt_s = rise_cnt_r;
                    end
                end else if (sck_fall_s) begin
                    shift_s = {shift_r[FrameBits-2:0], 1'b0};
                    so_s    = shift_r[FrameBits-2];
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s    = ST_CONVERT;
                conv_cnt_s = CONV_LOAD;
                so_s       = 1'b0;
                so_en_s    = 1'b0;
                busy_s     = 1'b1;
                rise_cnt_s = {RISE_W{1'b0}};
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_CONVERT;
            conv_cnt_r <= CONV_LOAD;
            conv_reg_r <= 11'd0;
            shift_r    <= {FrameBits{1'b0}};
            so_r       <= 1'b0;
            so_en_r    <= 1'b0;
            busy_r     <= 1'b1;
            frames_r   <= 8'd0;
            short_r    <= 1'b0;
            rise_cnt_r <= {RISE_W{1'b0}};
        end else if (srst) begin
            state_r    <= ST_CONVERT;
            conv_cnt_r <= CONV_LOAD;
            conv_reg_r <= 11'd0;
            shift_r    <= {FrameBits{1'b0}};
            so_r       <= 1'b0;
            so_en_r    <= 1'b0;
            busy_r     <= 1'b1;
            frames_r   <= 8'd0;
            short_r    <= 1'b0;
            rise_cnt_r <= {RISE_W{1'b0}};
        end else begin
            state_r    <= state_s;
            conv_cnt_r <= conv_cnt_s;
            conv_reg_r <= conv_reg_s;
            shift_r    <= shift_s;
            so_r       <= so_s;
            so_en_r    <= so_en_s;
            busy_r     <= busy_s;
            frames_r   <= frames_s;
            short_r    <= short_s;
            rise_cnt_r <= rise_cnt_s;
        end
    end

    assign bus.so          = so_r;
    assign bus.so_enable   = so_en_r;
    assign bus.conv_busy   = busy_r;
    assign bus.frames      = frames_r;
    assign bus.short_frame = short_r;
endmodule

// File: tb/tb_max6682_spi_responder.sv
// Directed bench for the MAX6682 responder: SPI master reads with a scoreboard
// of expected frames, plus status/latency checks around each CS edge.
module tb_max6682_spi_responder;
    logic clk = 1'b0;
    logic rst;
    logic srst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  exp_frames = 8'd0;

    max6682_spi_responder_if bus();

    max6682_spi_responder #(.ConvCycles(16), .FrameBits(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .srst (srst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: normal end, 1: CS rise with last SCK fall, 2: CS rise with last SCK rise
    task automatic do_read(input int nbits, input int mode, input logic exp_short,
                           output logic [31:0] data);
        data = 32'd0;
        bus.cs_n = 1'b0;
        tick(2);
        check("so_enable_before_sync_fall", {31'd0, bus.so_enable}, 32'd0);
        tick(1);
        check("so_enable_at_sync_fall", {31'd0, bus.so_enable}, 32'd1);
        check("conv_busy_in_shift", {31'd0, bus.conv_busy}, 32'd0);
        tick(2);
        for (int i = 0; i < nbits; i++) begin
            data = {data[30:0], bus.so};
            bus.sck = 1'b1;
            if (i == nbits - 1 && mode == 2) begin
                bus.cs_n = 1'b1;
            end else begin
                tick(4);
                bus.sck = 1'b0;
                if (i == nbits - 1 && mode == 1) bus.cs_n = 1'b1;
                else tick(4);
            end
        end
        if (mode == 0) bus.cs_n = 1'b1;
        tick(2);
        check("so_enable_before_sync_rise", {31'd0, bus.so_enable}, 32'd1);
        check("conv_busy_before_sync_rise", {31'd0, bus.conv_busy}, 32'd0);
        tick(1);
        check("so_enable_at_sync_rise", {31'd0, bus.so_enable}, 32'd0);
        check("so_after_frame", {31'd0, bus.so}, 32'd0);
        check("conv_busy_at_sync_rise", {31'd0, bus.conv_busy}, 32'd1);
        check("short_frame_pulse", {31'd0, bus.short_frame}, {31'd0, exp_short});
        bus.sck = 1'b0;
        tick(1);
        check("short_frame_clears", {31'd0, bus.short_frame}, 32'd0);
    endtask

    task automatic sb_read(input string tag, input int nbits, input int mode,
                           input logic [31:0] exp_data, input logic exp_short);
        logic [31:0] got;
        logic [31:0] want;
        exp_q.push_back(exp_data);
        do_read(nbits, mode, exp_short, got);
        if (!exp_short) exp_frames = exp_frames + 8'd1;
        check("scoreboard_nonempty", exp_q.size(), 32'd1);
        want = exp_q.pop_front();
        check(tag, got, want);
        check({tag, "_frames"}, {24'd0, bus.frames}, {24'd0, exp_frames});
    endtask

    initial begin
        rst = 1'b1;
        srst = 1'b0;
        bus.sck = 1'b0;
        bus.cs_n = 1'b1;
        bus.temperature = 11'h190;
        tick(2);
        check("reset_so", {31'd0, bus.so}, 32'd0);
        check("reset_so_enable", {31'd0, bus.so_enable}, 32'd0);
        check("reset_conv_busy", {31'd0, bus.conv_busy}, 32'd1);
        check("reset_frames", {24'd0, bus.frames}, 32'd0);
        check("reset_short", {31'd0, bus.short_frame}, 32'd0);
        rst = 1'b0;
        tick(10);
        check("busy_mid_conversion", {31'd0, bus.conv_busy}, 32'd1);
        tick(10);
        check("busy_after_conversion", {31'd0, bus.conv_busy}, 32'd0);

        sb_read("normal_read", 16, 0, 32'h3200, 1'b0);

        // abort: next conversion cut short, old result served
        bus.temperature = 11'h055;
        tick(5);
        sb_read("abort_read", 16, 0, 32'h3200, 1'b0);
        tick(20);
        sb_read("after_abort_read", 16, 0, 32'h0AA0, 1'b0);

        bus.temperature = 11'h7F0;
        tick(20);
        sb_read("negative_read", 16, 0, 32'hFE00, 1'b0);

        tick(20);
        sb_read("short_8_read", 8, 0, 32'h00FE, 1'b1);

        bus.temperature = 11'h2A5;
        tick(20);
        sb_read("long_20_read", 20, 0, 32'h54A00, 1'b0);

        tick(20);
        sb_read("cs_with_sck_fall", 16, 1, 32'h54A0, 1'b0);
        tick(20);
        sb_read("cs_with_sck_rise", 16, 2, 32'h54A0, 1'b1);

        while (exp_frames != 8'd255) begin
            tick(2);
            sb_read("wrap_loop_read", 16, 0, 32'h54A0, 1'b0);
        end
        check("frames_at_255", {24'd0, bus.frames}, 32'd255);
        tick(2);
        sb_read("wrap_read", 16, 0, 32'h54A0, 1'b0);
        check("frames_wrapped", {24'd0, bus.frames}, 32'd0);

        // reset in the middle of a frame
        bus.temperature = 11'h7FF;
        tick(20);
        bus.cs_n = 1'b0;
        tick(5);
        for (int i = 0; i < 7; i++) begin
            bus.sck = 1'b1;
            tick(4);
            bus.sck = 1'b0;
            tick(4);
        end
        bus.sck = 1'b1;
        tick(2);
        check("mid_frame_so_enable", {31'd0, bus.so_enable}, 32'd1);
        check("mid_frame_so", {31'd0, bus.so}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_so", {31'd0, bus.so}, 32'd0);
        check("async_reset_so_enable", {31'd0, bus.so_enable}, 32'd0);
        check("async_reset_busy", {31'd0, bus.conv_busy}, 32'd1);
        bus.cs_n = 1'b1;
        bus.sck = 1'b0;
        tick(2);
        rst = 1'b0;
        exp_frames = 8'd0;
        tick(3);
        check("after_reset_short", {31'd0, bus.short_frame}, 32'd0);
        check("after_reset_frames", {24'd0, bus.frames}, 32'd0);
        sb_read("read_after_reset", 16, 0, 32'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/max6682_spi_responder.md
Name: max6682_spi_responder

Overview:
- Behavioural-synthesizable model of the MAX6682 temperature sensor's SPI slave side, on a single clock.
- It is the counterpart of the on-chip SPI master application that reads 16-bit frames and extracts the 11 MSBs as the sensor value.
- It sits in the wsn-soc testbench and FPGA demo as the device on the far end of the SPI bus.
- It performs timed conversions while CS_n is high and shifts the last converted temperature out MSB-first under CPOL=0/CPHA=0 timing.

Parameters:
- ConvCycles, 16, Clk_i cycles per conversion (minimum 2).
- FrameBits, 16, SCK rising edges that make one complete frame.

Ports:
- Clk_i  input  1  system clock; must be at least 8x SCK frequency.
- Reset_i  input  1  asynchronous, active-high reset.
- SCK_i  input  1  SPI clock from master, asynchronous to Clk_i.
- CS_n_i  input  1  chip select from master, active low, asynchronous.
- SO_o  output  1  serial data out (MISO).
- SOEnable_o  output  1  high while SO_o is driven (tristate control).
- Temperature_i  input  11  two's-complement temperature, captured at the end of each conversion.
- ConvBusy_o  output  1  high while a conversion is running.
- Frames_o  output  8  count of complete frames; wraps 255->0.
- ShortFrame_o  output  1  one-cycle pulse when CS rises on an incomplete frame.

Behaviour:
- Synchronization and latency
  - SCK_i and CS_n_i each pass through a 2-flop synchronizer, then registered edge detection.
  - All reactions occur 3 Clk_i cycles after the pin edge.
- Reset values: state CONVERT, ConvCnt=ConvCycles-1, ConvReg=0, ShiftReg=0, SO_o=0, SOEnable_o=0, ConvBusy_o=1, Frames_o=0, ShortFrame_o=0, RiseCnt=0.
- CONVERT state (ConvBusy_o=1)
  - ConvCnt decrements each cycle.
  - At ConvCnt=0: ConvReg<=Temperature_i, ConvBusy_o<=0, go to READY.
  - CS falling edge during CONVERT aborts the conversion: ConvReg keeps its old value, go to SHIFT (same load as from READY).
- READY state (ConvBusy_o=0)
  - Holds until a CS falling edge.
  - On that edge: ShiftReg<={ConvReg,5'b00000}, SO_o<=ConvReg[10], SOEnable_o<=1, RiseCnt<=0, go to SHIFT.
- SHIFT state
  - SCK rising edge: RiseCnt increments, saturating at FrameBits.
  - SCK falling edge: ShiftReg<=ShiftReg<<1 (zero fill), SO_o<=new ShiftReg[15].
  - After 16 falling edges SO_o stays 0 for any extra clocks.
  - SCK edges are ignored outside SHIFT.
- CS rising edge in SHIFT
  - SO_o<=0, SOEnable_o<=0.
  - If RiseCnt==FrameBits: Frames_o<=Frames_o+1. Otherwise ShortFrame_o=1 for exactly one cycle.
  - Then ConvCnt<=ConvCycles-1, ConvBusy_o<=1, go to CONVERT.
- Simultaneous events: if a CS rising edge and an SCK edge are detected in the same cycle, CS wins and the SCK edge is discarded.
- Frame format: bits 15..5 = Temperature (MSB first), bits 4..0 = 0.
- Temperature_i is sampled only at conversion end; changes at any other time are invisible to the master.
- Reset mid-frame: outputs return to reset values immediately (asynchronous); the in-flight frame is not counted and no ShortFrame_o pulse is generated.
- No state is reachable except CONVERT, READY and SHIFT; the illegal state encoding recovers to CONVERT.

Test Plan:
- Normal read: Temperature_i=11'h190, wait past ConvCycles, master reads 16 bits -> captured 16'h3200, Frames_o=1, ConvBusy_o goes 1 three cycles after CS rises.
- Negative value: Temperature_i=11'h7F0 -> captured 16'hFE00; SOEnable_o high exactly between synchronized CS edges.
- Abort: after a first read of 11'h190, set Temperature_i=11'h055 and assert CS 5 cycles into the next conversion -> frame reads 16'h3200, ConvReg unchanged. The following full conversion then yields 16'h0AA0.
- Short frame: 8 SCK cycles then CS high -> ShortFrame_o one-cycle pulse, Frames_o unchanged. 20 SCK cycles -> bits 17..20 read 0 and Frames_o increments.
- Boundary and reset: 256 complete frames -> Frames_o wraps to 0. CS rise coincident with an SCK falling edge -> no extra shift observed. Reset_i pulsed at bit 7 -> SO_o=0, SOEnable_o=0 with no clock edge; the next read returns 16'h0000 if read before conversion completes.
